line_writer: RTL

LINE_WRITER -- requirements
Module: line_writer

---
 rtl/line_writer.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/line_writer.sv
// Line writer: buffers processed pixel words in a FWFT FIFO and drains each completed
// line to memory as fixed-length write bursts, tracking line/frame position.
module line_writer #(
    parameter int unsigned WIDTH     = 1600,
    parameter int unsigned LINES     = 1200,
    parameter int unsigned BURST     = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned DEPTH     = 2048
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        in_de_i,
    input  logic [31:0] in_data_i,
    input  logic        in_line_done_i,
    output logic        wr_req_o,
    output logic [31:0] wr_addr_o,
    output logic [7:0]  wr_len_o,
    input  logic        wr_ack_i,
    output logic        wr_valid_o,
    output logic [31:0] wr_data_o,
    input  logic        wr_ready_i,
    output logic        line_written_o,
    output logic        frame_done_o,
    output logic        overflow_o,
    output logic        busy_o
);
    localparam int unsigned NBURST      = WIDTH / BURST;
    localparam int unsigned AW          = $clog2(DEPTH);
    localparam int unsigned LW          = (LINES > 1) ? $clog2(LINES) : 1;
    localparam int unsigned BW          = (NBURST > 1) ? $clog2(NBURST) : 1;
    localparam int unsigned CW          = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [31:0] LINE_BYTES  = 32'(WIDTH * 4);
    localparam logic [31:0] BURST_BYTES = 32'(BURST * 4);
    localparam logic [AW:0] PTR_ONE     = (AW + 1)'(1);

    typedef enum logic [1:0] {StIdle, StCmd, StData, StNext} state_e;

    state_e         state_q, state_d;
    logic [31:0]    mem_q [DEPTH];
    logic [AW:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [15:0]    pending_q, pending_d;
    logic [LW-1:0]  line_idx_q, line_idx_d;
    logic [BW-1:0]  burst_idx_q, burst_idx_d;
    logic [CW-1:0]  beat_q, beat_d;
    logic [31:0]    addr_q, addr_d;
    logic [31:0]    line_addr_q, line_addr_d;
    logic           overflow_q, overflow_d;
    logic           fifo_empty, fifo_full, push, pop;
    logic           line_end, frame_end;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push       = in_de_i && !fifo_full;
    assign pop        = wr_valid_o && wr_ready_i;

    assign wr_ptr_d   = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    assign rd_ptr_d   = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    assign overflow_d = overflow_q || (in_de_i && fifo_full);

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= in_data_i;
        end
    end

    always_comb begin
        state_d     = state_q;
        burst_idx_d = burst_idx_q;
        line_idx_d  = line_idx_q;
        beat_d      = beat_q;
        addr_d      = addr_q;
        line_addr_d = line_addr_q;
        line_end    = 1'b0;
        frame_end   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pending_q != 16'd0) state_d = StCmd;
            end
            StCmd: begin
                if (wr_ack_i) begin
                    state_d = StData;
                    beat_d  = '0;
                end
            end
            StData: begin
                if (pop) begin
                    beat_d = beat_q + CW'(1);
                    if (beat_q == CW'(BURST - 1)) state_d = StNext;
                end
            end
            StNext: begin
                if (burst_idx_q == BW'(NBURST - 1)) begin
                    line_end    = 1'b1;
                    burst_idx_d = '0;
                    state_d     = StIdle;
                    if (line_idx_q == LW'(LINES - 1)) begin
                        frame_end   = 1'b1;
                        line_idx_d  = '0;
                        line_addr_d = BASE_ADDR;
                    end else begin
                        line_idx_d  = line_idx_q + LW'(1);
                        line_addr_d = line_addr_q + LINE_BYTES;
                    end
                    addr_d = line_addr_d;
                end else begin
                    burst_idx_d = burst_idx_q + BW'(1);
                    addr_d      = addr_q + BURST_BYTES;
                    state_d     = StCmd;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // A line completing in the same cycle a new one is announced leaves the count as is.
    always_comb begin
        pending_d = pending_q;
        if (in_line_done_i && !line_end) begin
            pending_d = pending_q + 16'd1;
        end else if (!in_line_done_i && line_end) begin
            pending_d = pending_q - 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            pending_q   <= 16'd0;
            line_idx_q  <= '0;
            burst_idx_q <= '0;
            beat_q      <= '0;
            addr_q      <= BASE_ADDR;
            line_addr_q <= BASE_ADDR;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            pending_q   <= pending_d;
            line_idx_q  <= line_idx_d;
            burst_idx_q <= burst_idx_d;
            beat_q      <= beat_d;
            addr_q      <= addr_d;
            line_addr_q <= line_addr_d;
            overflow_q  <= overflow_d;
        end
    end

    // Command and data buses read as zero whenever their strobe is low.
    assign wr_req_o       = (state_q == StCmd);
    assign wr_addr_o      = wr_req_o ? addr_q : 32'd0;
    assign wr_len_o       = wr_req_o ? 8'(BURST - 1) : 8'd0;
    assign wr_valid_o     = (state_q == StData) && !fifo_empty;
    assign wr_data_o      = wr_valid_o ? mem_q[rd_ptr_q[AW-1:0]] : 32'd0;
    assign line_written_o = line_end;
    assign frame_done_o   = frame_end;
    assign overflow_o     = overflow_q;
    assign busy_o         = (state_q != StIdle);

endmodule
